// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit combinational ALU: register file, command/response
// handshakes, and two-pass SUB/CMP built from negate-then-add.
module alu_cmd_sequencer #(
  parameter int W    = 16,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_ra,
  input  logic [$clog2(NREG)-1:0] cmd_rb,
  input  logic [W-1:0]            cmd_imm,
  input  logic                    cmd_cin,
  output logic [2:0]              alu_opc,
  output logic [W-1:0]            alu_inA,
  output logic [W-1:0]            alu_inB,
  output logic                    alu_inC,
  input  logic [W-1:0]            alu_outW,
  input  logic                    alu_zer,
  input  logic                    alu_neg,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_result,
  output logic                    rsp_zer,
  output logic                    rsp_neg,
  output logic                    rsp_err
);

  localparam int RW = $clog2(NREG);
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_LOADI = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [RW-1:0]   rd_q, ra_q, rb_q;
  logic            cin_q;
  logic [W-1:0]    tmp_q;
  logic [W-1:0]    regs [NREG];
  logic            is_macro;

  assign is_macro = (op_q == OP_SUB) || (op_q == OP_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    alu_opc   = 3'b111;
    alu_inA   = '0;
    alu_inB   = '0;
    alu_inC   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_op <= OP_CMP) ? EXEC1 : RESP;
      end
      EXEC1: begin
        // SUB/CMP first pass negates B so the second pass can add it to A
        if (is_macro) begin
          alu_opc = 3'b000;
          alu_inA = regs[rb_q];
          state_d = EXEC2;
        end else begin
          alu_opc = op_q[2:0];
          alu_inA = regs[ra_q];
          alu_inB = regs[rb_q];
          alu_inC = cin_q;
          state_d = RESP;
        end
      end
      EXEC2: begin
        alu_opc = 3'b010;
        alu_inA = regs[ra_q];
        alu_inB = tmp_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      cin_q      <= 1'b0;
      tmp_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zer    <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            ra_q    <= cmd_ra;
            rb_q    <= cmd_rb;
            cin_q   <= cmd_cin;
            rsp_err <= 1'b0;
            if (cmd_op == OP_LOADI) begin
              regs[cmd_rd] <= cmd_imm;
              rsp_result   <= cmd_imm;
              rsp_zer      <= (cmd_imm == '0);
              rsp_neg      <= cmd_imm[W-1];
              rsp_valid    <= 1'b1;
            end else if (cmd_op > OP_LOADI) begin
              rsp_result <= '0;
              rsp_zer    <= 1'b0;
              rsp_neg    <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
            end
          end
        end
        EXEC1: begin
          if (is_macro) begin
            tmp_q <= alu_outW;
          end else begin
            regs[rd_q] <= alu_outW;
            rsp_result <= alu_outW;
            rsp_zer    <= alu_zer;
            rsp_neg    <= alu_neg;
            rsp_valid  <= 1'b1;
          end
        end
        EXEC2: begin
          if (op_q != OP_CMP) regs[rd_q] <= alu_outW;
          rsp_result <= alu_outW;
          rsp_zer    <= alu_zer;
          rsp_neg    <= alu_neg;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural model of the 16-bit ALU
// attached to its ALU-side ports.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic        cmd_cin;
  logic [2:0]  alu_opc;
  logic [15:0] alu_inA, alu_inB, alu_outW;
  logic        alu_inC, alu_zer, alu_neg;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zer, rsp_neg, rsp_err;

  int checkCount = 0;
  int failCount  = 0;
  int lat;

  alu_cmd_sequencer #(.W(16), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .cmd_cin(cmd_cin),
    .alu_opc(alu_opc), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zer(rsp_zer), .rsp_neg(rsp_neg), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU; B>>>1 is written as an explicit sign-extending shift
  always_comb begin
    case (alu_opc)
      3'b000:  alu_outW = ~alu_inA + 16'd1;
      3'b001:  alu_outW = alu_inA + 16'd1;
      3'b010:  alu_outW = alu_inA + alu_inB + {15'd0, alu_inC};
      3'b011:  alu_outW = alu_inA + {alu_inB[15], alu_inB[15:1]};
      3'b100:  alu_outW = alu_inA & alu_inB;
      3'b101:  alu_outW = alu_inA | alu_inB;
      3'b110:  alu_outW = {alu_inA[7:0], alu_inB[7:0]};
      default: alu_outW = 16'd0;
    endcase
    alu_zer = (alu_outW == 16'd0);
    alu_neg = alu_outW[15];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic [15:0] res, input logic zer,
                          input logic neg, input logic err);
    checkOutput({tag, "_result"}, {16'd0, rsp_result}, {16'd0, res});
    checkOutput({tag, "_zer"}, {31'd0, rsp_zer}, {31'd0, zer});
    checkOutput({tag, "_neg"}, {31'd0, rsp_neg}, {31'd0, neg});
    checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
  endtask

  // Called on a falling edge; returns on the falling edge just after the acceptance edge
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [15:0] imm, input logic cin);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_cin = cin;
    cmd_valid = 1'b1;
    for (int n = 0; n < 20 && !cmd_ready; n++) @(negedge clk);
    checkOutput("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts rising edges from the acceptance edge (inclusive) until rsp_valid is seen
  task automatic waitRsp(output int edges);
    edges = 1;
    while (!rsp_valid && edges < 12) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic runCmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [15:0] imm, input logic cin);
    applyStimulus(op, rd, ra, rb, imm, cin);
    waitRsp(lat);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; cmd_cin = 1'b0;
    @(negedge clk); @(negedge clk);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_alu_opc", {29'd0, alu_opc}, 32'd7);
    checkOutput("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
    rst_n = 1'b1;

    runCmd(4'd10, 2'd0, 2'd0, 2'd0, 16'h0005, 1'b0);
    checkOutput("loadi_latency", lat, 32'd1);
    checkRsp("loadi_r0", 16'h0005, 1'b0, 1'b0, 1'b0);
    consume();
    runCmd(4'd10, 2'd1, 2'd0, 2'd0, 16'h0003, 1'b0);
    consume();

    runCmd(4'd2, 2'd2, 2'd0, 2'd1, 16'h0000, 1'b1);
    checkOutput("add_latency", lat, 32'd2);
    checkRsp("add", 16'h0009, 1'b0, 1'b0, 1'b0);
    consume();

    // SUB R3 = R1 - R0, observing both ALU passes
    applyStimulus(4'd8, 2'd3, 2'd1, 2'd0, 16'h0000, 1'b0);
    checkOutput("sub_exec1_opc", {29'd0, alu_opc}, 32'd0);
    checkOutput("sub_exec1_inA", {16'd0, alu_inA}, 32'h0005);
    @(negedge clk);
    checkOutput("sub_exec2_opc", {29'd0, alu_opc}, 32'd2);
    checkOutput("sub_exec2_inA", {16'd0, alu_inA}, 32'h0003);
    checkOutput("sub_exec2_inB", {16'd0, alu_inB}, 32'hFFFB);
    @(negedge clk);
    checkOutput("sub_rsp_valid_edge3", {31'd0, rsp_valid}, 32'd1);
    checkRsp("sub", 16'hFFFE, 1'b0, 1'b1, 1'b0);
    consume();
    runCmd(4'd5, 2'd3, 2'd3, 2'd3, 16'h0000, 1'b0);
    checkRsp("read_r3", 16'hFFFE, 1'b0, 1'b1, 1'b0);
    consume();

    runCmd(4'd9, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);
    checkOutput("cmp_latency", lat, 32'd3);
    checkRsp("cmp", 16'h0000, 1'b1, 1'b0, 1'b0);
    consume();
    runCmd(4'd5, 2'd2, 2'd0, 2'd0, 16'h0000, 1'b0);
    checkRsp("read_r0_after_cmp", 16'h0005, 1'b0, 1'b0, 1'b0);
    consume();

    runCmd(4'd12, 2'd0, 2'd0, 2'd0, 16'h7777, 1'b0);
    checkOutput("illegal_latency", lat, 32'd1);
    checkRsp("illegal", 16'h0000, 1'b0, 1'b0, 1'b1);
    consume();
    runCmd(4'd5, 2'd2, 2'd0, 2'd0, 16'h0000, 1'b0);
    checkRsp("read_r0_after_illegal", 16'h0005, 1'b0, 1'b0, 1'b0);
    consume();

    // Wraparound: 0 - 0x8000 = 0x8000
    runCmd(4'd10, 2'd2, 2'd0, 2'd0, 16'h8000, 1'b0);
    checkRsp("loadi_neg", 16'h8000, 1'b0, 1'b1, 1'b0);
    consume();
    runCmd(4'd10, 2'd1, 2'd0, 2'd0, 16'h0000, 1'b0);
    checkRsp("loadi_zero", 16'h0000, 1'b1, 1'b0, 1'b0);
    consume();
    runCmd(4'd8, 2'd3, 2'd1, 2'd2, 16'h0000, 1'b0);
    checkRsp("sub_wrap", 16'h8000, 1'b0, 1'b1, 1'b0);
    consume();

    runCmd(4'd10, 2'd0, 2'd0, 2'd0, 16'h1234, 1'b0);
    consume();
    runCmd(4'd10, 2'd1, 2'd0, 2'd0, 16'hABCD, 1'b0);
    consume();
    runCmd(4'd6, 2'd2, 2'd0, 2'd1, 16'h0000, 1'b0);
    checkRsp("concat", 16'h34CD, 1'b0, 1'b0, 1'b0);
    consume();

    // Backpressure with a second command waiting
    runCmd(4'd1, 2'd2, 2'd0, 2'd0, 16'h0000, 1'b0);
    cmd_op = 4'd4; cmd_rd = 2'd3; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("bp_rsp_result", {16'd0, rsp_result}, 32'h1235);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_hold_result", {16'd0, rsp_result}, 32'h1235);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("bp_accepted_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("bp_accepted_opc", {29'd0, alu_opc}, 32'd4);
    waitRsp(lat);
    checkOutput("bp_second_latency", lat, 32'd2);
    checkRsp("bp_and", 16'h0204, 1'b0, 1'b0, 1'b0);
    consume();

    // Asynchronous reset in the middle of a SUB
    applyStimulus(4'd8, 2'd3, 2'd0, 2'd1, 16'h0000, 1'b0);
    checkOutput("midsub_exec1_opc", {29'd0, alu_opc}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midsub_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midsub_rst_alu_opc", {29'd0, alu_opc}, 32'd7);
    checkOutput("midsub_rst_alu_inA", {16'd0, alu_inA}, 32'd0);
    checkOutput("midsub_rst_result", {16'd0, rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    runCmd(4'd1, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);
    checkRsp("post_rst_inc_r0", 16'h0001, 1'b0, 1'b0, 1'b0);
    consume();
    runCmd(4'd5, 2'd3, 2'd3, 2'd3, 16'h0000, 1'b0);
    checkRsp("post_rst_read_r3", 16'h0000, 1'b1, 1'b0, 1'b0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
